// File: rtl/step_anim_seq.sv
// Purpose : walk-cycle step sequencer; gives the sprite frame index for a moving object.
// Latency : all outputs registered; an advance is visible one cycle after its Frame_Tick.
// Backpres: none; Frame_Tick/Moving are sampled every cycle and never stalled.
//
// Ports:
//   Clk            system clock
//   Reset_n        synchronous active-low reset
//   Frame_Tick     one-cycle pulse per video frame
//   Moving         object is commanding motion this cycle
//   Pingpong       sequence mode select (1 = ping-pong); exists only with STEP_PINGPONG_EN
//   Obj_Step_Count current walk frame index
//   Step_Wrap      one-cycle pulse after an advance that lands on index 0
//   Walking        high while the sequencer is not idle
//
// Optional build macro: STEP_PINGPONG_EN adds the Pingpong port, the direction
// register and the ping-pong advance; without it the sequence always loops.

module step_anim_seq #(
  parameter  int NUM_FRAMES = 4,
  parameter  int DIV        = 8,
  localparam int STEP_W     = $clog2(NUM_FRAMES)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Frame_Tick,
  input  logic              Moving,
`ifdef STEP_PINGPONG_EN
  input  logic              Pingpong,
`endif
  output logic [STEP_W-1:0] Obj_Step_Count,
  output logic              Step_Wrap,
  output logic              Walking
);

  localparam int                DIV_W    = $clog2(DIV) + 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [STEP_W-1:0] IDX_LAST = STEP_W'(NUM_FRAMES - 1);
  localparam logic [STEP_W-1:0] IDX_ONE  = STEP_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   div_cnt, div_nxt;
  logic [STEP_W-1:0]  idx_nxt, idx_loop;
  logic               tick, adv, wrap_nxt;

`ifdef STEP_PINGPONG_EN
  // mode: 1 = ping-pong. dir: 0 = counting up, 1 = counting down.
  logic               mode, mode_nxt;
  logic               dir, dir_nxt;
`endif

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    idx_nxt   = Obj_Step_Count;
`ifdef STEP_PINGPONG_EN
    mode_nxt  = mode;
    dir_nxt   = dir;
`endif

    // Ticks only count once the object has left IDLE, so a tick coinciding
    // with the IDLE->WALK edge is not part of the first step period.
    tick     = Frame_Tick && (state != IDLE);
    adv      = tick && (div_cnt == DIV_LAST);
    idx_loop = (Obj_Step_Count == IDX_LAST) ? '0 : Obj_Step_Count + IDX_ONE;

    if (adv) begin
`ifdef STEP_PINGPONG_EN
      if (mode) begin
        if (!dir) begin
          idx_nxt = Obj_Step_Count + IDX_ONE;
          if (idx_nxt == IDX_LAST) dir_nxt = 1'b1;
        end else begin
          idx_nxt = Obj_Step_Count - IDX_ONE;
          if (idx_nxt == '0) dir_nxt = 1'b0;
        end
      end else begin
        idx_nxt = idx_loop;
      end
`else
      idx_nxt = idx_loop;
`endif
    end

    wrap_nxt = adv && (idx_nxt == '0);

    // State decisions look at the post-advance index so a step due this
    // cycle is never lost when Moving drops at the same time.
    case (state)
      IDLE: begin
        if (Moving) begin
          state_nxt = WALK;
`ifdef STEP_PINGPONG_EN
          mode_nxt  = Pingpong;
          dir_nxt   = 1'b0;
`endif
        end
      end
      WALK: begin
        if (!Moving) state_nxt = (idx_nxt == '0) ? IDLE : SETTLE;
      end
      SETTLE: begin
        if (Moving)        state_nxt = WALK;
        else if (wrap_nxt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Prescaler survives SETTLE<->WALK so resuming never stretches a step.
    if (state_nxt == IDLE) div_nxt = '0;
    else if (tick)         div_nxt = adv ? '0 : div_cnt + DIV_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state          <= IDLE;
      div_cnt        <= '0;
      Obj_Step_Count <= '0;
      Step_Wrap      <= 1'b0;
      Walking        <= 1'b0;
`ifdef STEP_PINGPONG_EN
      mode           <= 1'b0;
      dir            <= 1'b0;
`endif
    end else begin
      state          <= state_nxt;
      div_cnt        <= div_nxt;
      Obj_Step_Count <= idx_nxt;
      Step_Wrap      <= wrap_nxt;
      Walking        <= (state_nxt != IDLE);
`ifdef STEP_PINGPONG_EN
      mode           <= mode_nxt;
      dir            <= dir_nxt;
`endif
    end
  end

endmodule

// File: doc/step_anim_seq.md
Name: step_anim_seq

Overview:
Parametrised walk-cycle animation sequencer for sprite objects such as the player and zombies. It produces the sprite step index used to select a walking frame from sprite ROM. It advances one step every DIV frame ticks while the object moves, then finishes the current cycle back to the idle frame once motion stops. Its output feeds the sprite address logic alongside the direction index.

Parameters:
NUM_FRAMES, 4, number of walk frames; legal range 2..16.
DIV, 8, Frame_Tick pulses per step advance; legal range 1..255.
STEP_W, $clog2(NUM_FRAMES), width of the step index (derived localparam, not overridable).

Ports:
Clk  in  1  system clock.
Reset_n  in  1  synchronous active-low reset.
Frame_Tick  in  1  single-cycle pulse, once per video frame.
Moving  in  1  object is commanding motion this cycle.
Pingpong  in  1  mode select, 1 = ping-pong sequence; port exists only with STEP_PINGPONG_EN.
Obj_Step_Count  out  STEP_W  current walk frame index.
Step_Wrap  out  1  one-cycle pulse when the index returns to 0 by advancing.
Walking  out  1  high whenever the state is not IDLE.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-low on Reset_n.
- Reset (Reset_n=0 at a posedge) overrides all other inputs, including mid-walk. After reset:
  - state=IDLE, Obj_Step_Count=0, div_cnt=0, dir=up, mode=loop.
  - Step_Wrap=0, Walking=0.
- All outputs are registered.
- Prescaler: div_cnt, width $clog2(DIV)+1.
  - Counts only Frame_Tick pulses seen while in WALK or SETTLE.
  - A tick with div_cnt==DIV-1 clears div_cnt and performs one advance that same edge.
  - Any other tick increments div_cnt.
  - div_cnt holds in IDLE and is cleared on entry to IDLE.
- Advance, loop mode: index NUM_FRAMES-1 goes to 0; otherwise index+1.
- Advance, ping-pong mode:
  - dir=up: index+1. On reaching NUM_FRAMES-1, dir flips to down.
  - dir=down: index-1. On reaching 0, dir flips to up.
  - NUM_FRAMES=2 degenerates to 0,1,0,1.
- Step_Wrap: asserted for exactly the one cycle after an advance whose new index is 0. It is never asserted by reset or by an IDLE entry.
- State machine:
  - IDLE: index held at 0. Frame_Tick is ignored. Moving=1 → WALK. On this transition the mode register latches Pingpong (latched as 0 without the macro), and dir=up.
  - WALK: Moving=0 → IDLE if the next index (after any advance this cycle) is 0; otherwise SETTLE.
  - SETTLE: keeps advancing at the same rate.
    - Moving=1 → WALK. div_cnt, index and dir are preserved; there is no stall.
    - Otherwise, when an advance lands on 0 → IDLE on that same edge.
- Simultaneous events: an advance is always applied in the cycle it is due, even if Moving falls in that same cycle. State decisions use the post-advance index.
- Mode changes on Pingpong during WALK or SETTLE have no effect until the next IDLE→WALK transition.
- First advance after IDLE→WALK happens on exactly the DIV-th Frame_Tick seen in WALK. A tick in the same cycle as the IDLE→WALK transition does not count.

Optional Feature:
STEP_PINGPONG_EN
- Defined: the Pingpong port, dir register and ping-pong advance logic exist, with behaviour as above.
- Undefined: no Pingpong port and no dir register. The mode is permanently loop and the sequence is 0,1,…,NUM_FRAMES-1,0.
- Loop-mode behaviour is cycle-identical in both builds.

Test Plan:
1. Reset mid-walk: drive Reset_n=0 one cycle while index=2, Walking=1 → next cycle Obj_Step_Count=0, Walking=0, Step_Wrap=0; with Reset_n=1 and Moving=0, 10 Frame_Ticks leave index at 0.
2. Loop walk (NUM_FRAMES=4, DIV=2): Moving=1, Frame_Tick every 4 cycles → index steps 1,2,3,0, each change 2 ticks apart; Step_Wrap high exactly one cycle at 3→0; Walking=1 throughout.
3. Settle: Moving drops at index 2 → advances continue to 3 then 0; Walking falls on the 0 edge; a further 6 ticks leave index at 0 with no Step_Wrap.
4. Resume during SETTLE: Moving reasserted at index 3 with div_cnt=1 → the next tick advances to 0 (no prescaler restart); Step_Wrap pulses; Walking stays 1; state is WALK.
5. Ping-pong (macro defined, Pingpong=1 at start, NUM_FRAMES=4, DIV=1): index 1,2,3,2,1,0,1; Step_Wrap only on 1→0. Toggling Pingpong to 0 mid-walk leaves the sequence unchanged.
6. Edge timing: Frame_Tick in the same cycle as Moving 0→1 from IDLE, with DIV=2 → the first advance occurs on the 2nd subsequent tick, not the 1st.
